// File: rtl/xf_cp_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : xf_cp_dispatch
// Description : CP-bus write front-end for XF. It decodes CP writes into
//               NUM_REGIONS regions and queues them in a FIFO with per-region
//               valid/ready handshakes. It also supports an indexed burst mode
//               with a header word followed by auto-incrementing data words.
//               Define XF_DISPATCH_ERR_EN to enable bad-region error status.
// Revision    : 1.0 - initial release
// ============================================================================
module xf_cp_dispatch #(
    parameter int ADDR_W      = 16,
    parameter int SEL_W       = 4,
    parameter int NUM_REGIONS = 2,
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             cp_addr,
    input  logic                          cp_write,
    input  logic                          cp_burst,
    input  logic [DATA_W-1:0]             cp_write_data,
    output logic                          cp_ready,
    output logic [NUM_REGIONS-1:0]        xf_valid,
    input  logic [NUM_REGIONS-1:0]        xf_ready,
    output logic [ADDR_W-SEL_W-1:0]       xf_addr,
    output logic [DATA_W-1:0]             xf_data,
    output logic                          burst_active,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          err_clear,
    output logic                          err_flag,
    output logic [7:0]                    err_count
);

    localparam int             c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int             c_LVL_W = c_PTR_W + 1;
    localparam int             c_LOC_W = ADDR_W - SEL_W;
    localparam logic [SEL_W:0] c_NREG  = (SEL_W+1)'(NUM_REGIONS);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_BURST = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [ADDR_W-1:0]   r_cur;
    logic [16:0]         r_rem;

    logic [SEL_W-1:0]    r_mem_sel  [FIFO_DEPTH];
    logic [c_LOC_W-1:0]  r_mem_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_mem_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_LVL_W-1:0]  r_count;
    logic [c_LOC_W-1:0]  r_last_addr;
    logic [DATA_W-1:0]   r_last_data;

    logic                w_accept;
    logic                w_hdr;
    logic                w_word;
    logic [ADDR_W-1:0]   w_dec_addr;
    logic [SEL_W-1:0]    w_sel;
    logic                w_good;
    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic [SEL_W-1:0]    w_head_sel;

    assign w_empty    = (r_count == '0);
    assign cp_ready   = (r_count != c_LVL_W'(FIFO_DEPTH));
    assign w_accept   = cp_write & cp_ready;
    assign w_hdr      = w_accept & (r_state == c_ST_IDLE) & cp_burst;
    assign w_word     = w_accept & ~w_hdr;

    // In a burst the address comes from the running pointer, never from the bus.
    assign w_dec_addr = (r_state == c_ST_BURST) ? r_cur : cp_addr;
    assign w_sel      = w_dec_addr[ADDR_W-1 -: SEL_W];
    assign w_good     = ({1'b0, w_sel} < c_NREG);
    assign w_push     = w_word & w_good;

    assign w_head_sel = r_mem_sel[r_rd_ptr];
    assign w_pop      = |(xf_valid & xf_ready);

    always_comb begin
        xf_valid = '0;
        if (!w_empty) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (w_head_sel == SEL_W'(i)) xf_valid[i] = 1'b1;
            end
        end
    end

    // An empty FIFO presents the most recently consumed word.
    assign xf_addr      = w_empty ? r_last_addr : r_mem_addr[r_rd_ptr];
    assign xf_data      = w_empty ? r_last_data : r_mem_data[r_rd_ptr];
    assign fifo_level   = r_count;
    assign burst_active = (r_state == c_ST_BURST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_hdr) w_state_nxt = c_ST_BURST;
            c_ST_BURST: if (w_accept && (r_rem == 17'd1)) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_cur   <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hdr) begin
                r_cur <= cp_write_data[ADDR_W-1:0];
                r_rem <= {1'b0, cp_write_data[31:16]} + 17'd1;
            end else if (w_accept && (r_state == c_ST_BURST)) begin
                r_cur <= r_cur + ADDR_W'(1);
                r_rem <= r_rem - 17'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_sel[r_wr_ptr]  <= w_sel;
            r_mem_addr[r_wr_ptr] <= w_dec_addr[c_LOC_W-1:0];
            r_mem_data[r_wr_ptr] <= cp_write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_last_addr <= '0;
            r_last_data <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + c_PTR_W'(1);
                r_last_addr <= r_mem_addr[r_rd_ptr];
                r_last_data <= r_mem_data[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_LVL_W'(1);
                2'b01:   r_count <= r_count - c_LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef XF_DISPATCH_ERR_EN
    logic       w_bad;
    logic       r_err_flag;
    logic [7:0] r_err_count;

    assign w_bad = w_word & ~w_good;

    // A clear in the same cycle as a bad write discards that write's error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_flag  <= 1'b0;
            r_err_count <= 8'd0;
        end else if (err_clear) begin
            r_err_flag  <= 1'b0;
            r_err_count <= 8'd0;
        end else if (w_bad) begin
            r_err_flag <= 1'b1;
            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_flag  = r_err_flag;
    assign err_count = r_err_count;
`else
    logic w_unused_err_clear;
    assign w_unused_err_clear = err_clear;
    assign err_flag           = 1'b0;
    assign err_count          = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xf_cp_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_xf_cp_dispatch
// Description : Scoreboard testbench for xf_cp_dispatch (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xf_cp_dispatch;

`ifdef XF_DISPATCH_ERR_EN
    localparam bit c_ERR_EN = 1'b1;
`else
    localparam bit c_ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cp_addr;
    logic        cp_write;
    logic        cp_burst;
    logic [31:0] cp_write_data;
    logic        cp_ready;
    logic [1:0]  xf_valid;
    logic [1:0]  xf_ready;
    logic [11:0] xf_addr;
    logic [31:0] xf_data;
    logic        burst_active;
    logic [2:0]  fifo_level;
    logic        err_clear;
    logic        err_flag;
    logic [7:0]  err_count;

    xf_cp_dispatch dut (
        .clk           (clk),
        .reset         (reset),
        .cp_addr       (cp_addr),
        .cp_write      (cp_write),
        .cp_burst      (cp_burst),
        .cp_write_data (cp_write_data),
        .cp_ready      (cp_ready),
        .xf_valid      (xf_valid),
        .xf_ready      (xf_ready),
        .xf_addr       (xf_addr),
        .xf_data       (xf_data),
        .burst_active  (burst_active),
        .fifo_level    (fifo_level),
        .err_clear     (err_clear),
        .err_flag      (err_flag),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          region;
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t q_exp[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model of the burst sequencer
    bit          m_burst = 1'b0;
    logic [15:0] m_cur   = '0;
    int          m_rem   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic void model_push(input logic [15:0] a, input logic [31:0] d);
        exp_t e;
        if (a[15:12] < 4'd2) begin
            e.region = int'(a[15:12]);
            e.addr   = a[11:0];
            e.data   = d;
            q_exp.push_back(e);
        end
    endfunction

    function automatic void model_accept(input logic [15:0] a, input logic [31:0] d, input logic b);
        if (!m_burst) begin
            if (b) begin
                m_cur   = d[15:0];
                m_rem   = int'(d[31:16]) + 1;
                m_burst = 1'b1;
            end else begin
                model_push(a, d);
            end
        end else begin
            model_push(m_cur, d);
            m_cur = m_cur + 16'd1;
            m_rem--;
            if (m_rem == 0) m_burst = 1'b0;
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic cp_wr(input logic [15:0] a, input logic [31:0] d, input logic b);
        int t;
        t = 0;
        cp_addr       = a;
        cp_write_data = d;
        cp_burst      = b;
        cp_write      = 1'b1;
        @(negedge clk);
        while (!cp_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!cp_ready) chk("cp_wr_timeout", 64'(cp_ready), 64'd1);
        else           model_accept(a, d, b);
        @(posedge clk);
        #1;
        cp_write = 1'b0;
        cp_burst = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        xf_ready = 2'b11;
        @(negedge clk);
        while (fifo_level != 3'd0 && t < 100) begin
            t++;
            @(negedge clk);
        end
        chk("drain_level", 64'(fifo_level), 64'd0);
        chk("drain_scoreboard_empty", 64'(q_exp.size()), 64'd0);
        @(posedge clk);
        #1;
        xf_ready = 2'b00;
    endtask

    always @(negedge clk) begin
        if (|(xf_valid & xf_ready)) begin
            if (q_exp.size() == 0) begin
                chk("unexpected_pop", 64'(xf_valid), 64'd0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                chk("pop_region", 64'(xf_valid), 64'(2'b01 << e.region));
                chk("pop_addr",   64'(xf_addr),  64'(e.addr));
                chk("pop_data",   64'(xf_data),  64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cp_addr = '0; cp_write = 1'b0; cp_burst = 1'b0;
        cp_write_data = '0; xf_ready = 2'b00; err_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_cp_ready", 64'(cp_ready), 64'd1);
        chk("rst_xf_valid", 64'(xf_valid), 64'd0);
        chk("rst_xf_addr",  64'(xf_addr), 64'd0);
        chk("rst_xf_data",  64'(xf_data), 64'd0);
        chk("rst_burst",    64'(burst_active), 64'd0);
        chk("rst_level",    64'(fifo_level), 64'd0);
        chk("rst_err_flag", 64'(err_flag), 64'd0);
        chk("rst_err_cnt",  64'(err_count), 64'd0);
        @(posedge clk); #1;

        // Single write: no bypass in the accept cycle, visible after the edge
        cp_addr = 16'h0012; cp_write_data = 32'hDEADBEEF; cp_burst = 1'b0; cp_write = 1'b1;
        @(negedge clk);
        chk("no_bypass_valid", 64'(xf_valid), 64'd0);
        model_accept(16'h0012, 32'hDEADBEEF, 1'b0);
        @(posedge clk); #1 cp_write = 1'b0;
        @(negedge clk);
        chk("single_valid", 64'(xf_valid), 64'h1);
        chk("single_addr",  64'(xf_addr), 64'h012);
        chk("single_level", 64'(fifo_level), 64'd1);
        @(posedge clk); #1;
        drain();
        chk("hold_last_addr", 64'(xf_addr), 64'h012);
        chk("hold_last_data", 64'(xf_data), 64'hDEADBEEF);

        // Burst across region boundary
        cp_wr(16'h0000, 32'h0002_0FFE, 1'b1);
        @(negedge clk);
        chk("burst_active_hdr", 64'(burst_active), 64'd1);
        chk("burst_hdr_no_push", 64'(fifo_level), 64'd0);
        @(posedge clk); #1;
        cp_wr(16'h3FFF, 32'hB0000001, 1'b0);
        cp_wr(16'h3FFF, 32'hB0000002, 1'b1);
        cp_wr(16'h3FFF, 32'hB0000003, 1'b0);
        @(negedge clk);
        chk("burst_active_end", 64'(burst_active), 64'd0);
        chk("burst_level", 64'(fifo_level), 64'd3);
        @(posedge clk); #1;
        drain();

        // Full FIFO and stalled writer
        for (int i = 1; i <= 4; i++) cp_wr(16'(i), 32'(32'hF000_0000 + i), 1'b0);
        @(negedge clk);
        chk("full_cp_ready", 64'(cp_ready), 64'd0);
        chk("full_level", 64'(fifo_level), 64'd4);
        @(posedge clk); #1;
        fork
            cp_wr(16'h1005, 32'hF000_0005, 1'b0);
            begin
                repeat (3) @(negedge clk);
                chk("stall_level", 64'(fifo_level), 64'd4);
                @(posedge clk); #1 xf_ready = 2'b11;
                @(negedge clk);
                chk("full_pop_cp_ready", 64'(cp_ready), 64'd0);
                @(posedge clk); #1 xf_ready = 2'b00;
            end
        join
        @(negedge clk);
        chk("refill_level", 64'(fifo_level), 64'd4);
        @(posedge clk); #1;
        drain();

        // Bad region
        cp_wr(16'h3000, 32'h0BAD0001, 1'b0);
        @(negedge clk);
        chk("bad_no_push", 64'(fifo_level), 64'd0);
        chk("bad_err_flag", 64'(err_flag), c_ERR_EN ? 64'd1 : 64'd0);
        chk("bad_err_cnt",  64'(err_count), c_ERR_EN ? 64'd1 : 64'd0);
        @(posedge clk); #1 err_clear = 1'b1;
        @(posedge clk); #1 err_clear = 1'b0;
        @(negedge clk);
        chk("clr_err_flag", 64'(err_flag), 64'd0);
        chk("clr_err_cnt",  64'(err_count), 64'd0);
        @(posedge clk); #1;
        err_clear = 1'b1;
        cp_wr(16'h3000, 32'h0BAD0002, 1'b0);
        err_clear = 1'b0;
        @(negedge clk);
        chk("clr_wins_cnt", 64'(err_count), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 257; i++) cp_wr(16'h3000, 32'(i), 1'b0);
        @(negedge clk);
        chk("sat_err_cnt",  64'(err_count), c_ERR_EN ? 64'd255 : 64'd0);
        chk("sat_err_flag", 64'(err_flag), c_ERR_EN ? 64'd1 : 64'd0);
        chk("sat_level", 64'(fifo_level), 64'd0);
        @(posedge clk); #1;

        // Reset mid-burst
        cp_wr(16'h0040, 32'h11110040, 1'b0);
        cp_wr(16'h0000, 32'h0004_0100, 1'b1);
        @(negedge clk);
        chk("midburst_active", 64'(burst_active), 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        q_exp.delete();
        m_burst = 1'b0;
        @(negedge clk);
        chk("abort_burst", 64'(burst_active), 64'd0);
        chk("abort_level", 64'(fifo_level), 64'd0);
        chk("abort_valid", 64'(xf_valid), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        cp_wr(16'h1034, 32'hCAFE0001, 1'b0);
        @(negedge clk);
        chk("post_rst_valid", 64'(xf_valid), 64'h2);
        chk("post_rst_addr",  64'(xf_addr), 64'h034);
        @(posedge clk); #1;
        drain();

        // Streaming push+pop at level 2
        cp_wr(16'h0200, 32'h5000_0000, 1'b0);
        cp_wr(16'h1201, 32'h5000_0001, 1'b0);
        fork
            begin
                xf_ready = 2'b11;
                for (int i = 2; i < 12; i++)
                    cp_wr(16'(((i % 2) << 12) | (16'h0200 + i)), 32'(32'h5000_0000 + i), 1'b0);
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    chk("stream_level", 64'(fifo_level), 64'd2);
                end
            end
        join
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
